// File: rtl/m_sequence_gen.sv
// Fibonacci LFSR m-sequence generator with seed load, all-zero recovery, period marker and
// optional self-synchronising loopback checker (built when MSEQ_CHECKER_EN is defined).
//   state | meaning
//   HUNT  | filling history with WIDTH received bits, chk_sync=0
//   LOCK  | predicting each received bit from history, chk_sync=1
module m_sequence_gen #(
  parameter int              WIDTH    = 7,
  parameter logic [WIDTH-1:0] TAPS    = 'h44,
  parameter logic [WIDTH-1:0] SEED    = '1,
  parameter int              LOSS_THR = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  output logic             data_out,
  output logic             data_valid,
  output logic             load,
  output logic             frame_start,
  output logic             lockup,
  output logic [WIDTH-1:0] state_out,
  input  logic             chk_in,
  input  logic             chk_valid,
  output logic             chk_sync,
  output logic             chk_err,
  output logic [15:0]      err_cnt
);

  localparam logic [WIDTH-1:0] CNT_LAST = ~(WIDTH'(1));

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] bit_cnt_q;
  logic             primed_q;
  logic             fb;

  assign fb        = ^(state_q & TAPS);
  assign state_out = state_q;

  // primed_q marks that one advance has happened since reset/seed, so a pause on ena
  // resumes emission on the first enabled cycle without dropping a bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SEED;
      bit_cnt_q   <= '0;
      primed_q    <= 1'b0;
      data_out    <= 1'b0;
      data_valid  <= 1'b0;
      load        <= 1'b0;
      frame_start <= 1'b0;
      lockup      <= 1'b0;
    end else if (seed_load) begin
      state_q     <= (seed_in == '0) ? SEED : seed_in;
      lockup      <= (seed_in == '0);
      bit_cnt_q   <= '0;
      primed_q    <= 1'b0;
      data_valid  <= 1'b0;
      load        <= 1'b0;
      frame_start <= 1'b0;
    end else if (ena) begin
      load <= 1'b1;
      if (state_q == '0) begin
        state_q     <= SEED;
        lockup      <= 1'b1;
        bit_cnt_q   <= '0;
        data_valid  <= 1'b0;
        frame_start <= 1'b0;
      end else begin
        state_q  <= {state_q[WIDTH-2:0], fb};
        lockup   <= 1'b0;
        primed_q <= 1'b1;
        if (primed_q) begin
          data_out    <= state_q[WIDTH-1];
          data_valid  <= 1'b1;
          frame_start <= (bit_cnt_q == '0);
          bit_cnt_q   <= (bit_cnt_q == CNT_LAST) ? '0 : bit_cnt_q + WIDTH'(1);
        end else begin
          data_valid  <= 1'b0;
          frame_start <= 1'b0;
        end
      end
    end else begin
      load        <= 1'b0;
      data_valid  <= 1'b0;
      frame_start <= 1'b0;
      lockup      <= 1'b0;
    end
  end

`ifdef MSEQ_CHECKER_EN
  typedef enum logic {HUNT, LOCK} chk_state_t;

  chk_state_t       cst_q, cst_d;
  logic [WIDTH-1:0] hist_q, hist_d;
  logic [4:0]       fill_q, fill_d;
  logic [3:0]       win_q, win_d;
  logic [4:0]       mis_q, mis_d;
  logic [15:0]      err_cnt_q, err_cnt_d;
  logic             chk_err_q, err_d;
  logic             pred, miss;

  assign pred = ^(hist_q & TAPS);

  always_ff @(posedge clk) begin
    if (rst) begin
      cst_q     <= HUNT;
      hist_q    <= '0;
      fill_q    <= '0;
      win_q     <= '0;
      mis_q     <= '0;
      err_cnt_q <= '0;
      chk_err_q <= 1'b0;
    end else begin
      cst_q     <= cst_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      win_q     <= win_d;
      mis_q     <= mis_d;
      err_cnt_q <= err_cnt_d;
      chk_err_q <= err_d;
    end
  end

  always_comb begin
    cst_d     = cst_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    win_d     = win_q;
    mis_d     = mis_q;
    err_cnt_d = err_cnt_q;
    err_d     = 1'b0;
    miss      = 1'b0;
    if (chk_valid) begin
      hist_d = {hist_q[WIDTH-2:0], chk_in};
      case (cst_q)
        HUNT: begin
          if (fill_q == 5'(WIDTH - 1)) begin
            cst_d  = LOCK;
            fill_d = '0;
            win_d  = '0;
            mis_d  = '0;
          end else begin
            fill_d = fill_q + 5'd1;
          end
        end
        LOCK: begin
          miss = chk_in ^ pred;
          if (miss) begin
            err_d = 1'b1;
            if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
          end
          // The mismatch that reaches the threshold ends the window and drops sync.
          if (miss && ((mis_q + 5'd1) >= 5'(LOSS_THR))) begin
            cst_d  = HUNT;
            fill_d = '0;
            win_d  = '0;
            mis_d  = '0;
          end else if (win_q == 4'd15) begin
            win_d = '0;
            mis_d = '0;
          end else begin
            win_d = win_q + 4'd1;
            mis_d = mis_q + {4'd0, miss};
          end
        end
      endcase
    end
  end

  assign chk_sync = (cst_q == LOCK);
  assign chk_err  = chk_err_q;
  assign err_cnt  = err_cnt_q;
`else
  logic unused_chk;
  localparam logic unused_thr = (LOSS_THR > 0);
  assign unused_chk = chk_in ^ chk_valid ^ unused_thr;
  assign chk_sync   = 1'b0;
  assign chk_err    = 1'b0;
  assign err_cnt    = 16'd0;
`endif

endmodule

// File: tb/tb_m_sequence_gen.sv
// Scoreboard bench for m_sequence_gen (default WIDTH=7, TAPS=7'h44, SEED=7'h7F).
// Expected bits come from b[n] = b[n-7] ^ b[n-3] seeded with the hand-derived 1111110.
module tb_m_sequence_gen;
  localparam int W = 7;

  logic clk = 1'b0;
  logic rst, ena, seed_load;
  logic [W-1:0] seed_in;
  logic chk_in, chk_valid;
  logic data_out, data_valid, load, frame_start, lockup, chk_sync, chk_err;
  logic [W-1:0] state_out;
  logic [15:0] err_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct packed {logic b; logic fs;} exp_t;
  exp_t expq[$];

  logic ref_bits [1100];
  int   mon_n = 0;
  int   ones127 = 0;

  logic loop_mode = 1'b0;
  logic flip = 1'b0;
  logic ext_in = 1'b0;
  logic ext_valid = 1'b0;

  assign chk_in    = loop_mode ? (data_out ^ flip) : ext_in;
  assign chk_valid = loop_mode ? data_valid : ext_valid;

  always #5 clk = ~clk;

  m_sequence_gen dut (
    .clk(clk), .rst(rst), .ena(ena), .seed_load(seed_load), .seed_in(seed_in),
    .data_out(data_out), .data_valid(data_valid), .load(load), .frame_start(frame_start),
    .lockup(lockup), .state_out(state_out), .chk_in(chk_in), .chk_valid(chk_valid),
    .chk_sync(chk_sync), .chk_err(chk_err), .err_cnt(err_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".data_out"},    data_out,    0);
    chk({tag, ".data_valid"},  data_valid,  0);
    chk({tag, ".load"},        load,        0);
    chk({tag, ".frame_start"}, frame_start, 0);
    chk({tag, ".lockup"},      lockup,      0);
    chk({tag, ".state_out"},   state_out,   7'h7F);
    chk({tag, ".chk_sync"},    chk_sync,    0);
    chk({tag, ".chk_err"},     chk_err,     0);
    chk({tag, ".err_cnt"},     err_cnt,     0);
  endtask

  task automatic push_ref(input int count);
    exp_t e;
    for (int i = 0; i < count; i++) begin
      e.b  = ref_bits[i];
      e.fs = ((i % 127) == 0);
      expq.push_back(e);
    end
  endtask

  // Monitor: every presented bit pops one expectation.
  always @(negedge clk) begin
    exp_t e;
    if (data_valid) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_bit: got data_valid=1 data_out=%0b expected no output", data_out);
      end else begin
        e = expq.pop_front();
        chk("data_out", data_out, e.b);
        chk("frame_start", frame_start, e.fs);
      end
      if (mon_n < 127) ones127 += int'(data_out);
      mon_n++;
    end
  end

  logic [W-1:0] seed_seq [6] = '{7'h02, 7'h04, 7'h09, 7'h12, 7'h24, 7'h49};

  initial begin
    logic [6:0] init_v;
    exp_t e;
    int nv, lows, errp, sync_low, got, dropped, nz;
    bit paused;

    rst = 1'b1; ena = 1'b0; seed_load = 1'b0; seed_in = '0;
    init_v = 7'b1111110;
    for (int i = 0; i < 7; i++) ref_bits[i] = init_v[6-i];
    for (int i = 7; i < 1100; i++) ref_bits[i] = ref_bits[i-7] ^ ref_bits[i-3];

    repeat (2) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;

    // Free run from reset with a 5-cycle pause after bit 100.
    push_ref(260);
    ena = 1'b1;
    @(negedge clk);
    chk("load_after_edge1", load, 1);
    chk("dv_after_edge1", data_valid, 0);
    chk("state_after_edge1", state_out, 7'h7E);
    nv = 0; paused = 1'b0;
    for (int c = 0; c < 600 && nv < 260; c++) begin
      @(negedge clk);
      if (data_valid) nv++;
      if (nv == 100 && !paused) begin
        paused = 1'b1;
        ena = 1'b0;
        lows = 0;
        for (int k = 0; k < 6; k++) begin
          @(negedge clk);
          if (data_valid) nv++; else lows++;
          if (k == 4) ena = 1'b1;
        end
        chk("pause_gap_cycles", lows, 5);
      end
      if (nv == 260) ena = 1'b0;
    end
    ena = 1'b0;
    chk("run_bit_count", nv, 260);
    @(negedge clk);
    chk("run_no_extra_bit", data_valid, 0);
    chk("run_queue_drained", expq.size(), 0);
    chk("ones_per_period", ones127, 64);

    // Zero seed with ena high: seed wins, recovers to SEED, one lockup pulse.
    seed_load = 1'b1; seed_in = '0; ena = 1'b1;
    @(negedge clk);
    chk("zero_seed_state", state_out, 7'h7F);
    chk("zero_seed_lockup", lockup, 1);
    chk("zero_seed_load", load, 0);
    chk("zero_seed_dv", data_valid, 0);
    seed_load = 1'b0; ena = 1'b0;
    @(negedge clk);
    chk("lockup_single_pulse", lockup, 0);
    chk("hold_state", state_out, 7'h7F);

    seed_load = 1'b1; seed_in = 7'h01;
    @(negedge clk);
    chk("seed01_state", state_out, 7'h01);
    chk("seed01_lockup", lockup, 0);
    seed_load = 1'b0;
    e.b = 1'b0; e.fs = 1'b1; expq.push_back(e);
    e.fs = 1'b0;
    for (int i = 0; i < 4; i++) expq.push_back(e);
    ena = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("seed01_step%0d", i), state_out, seed_seq[i]);
    end
    ena = 1'b0;
    @(negedge clk);
    chk("seed01_queue_drained", expq.size(), 0);

    rst = 1'b1; seed_load = 1'b1; seed_in = 7'h01;
    @(negedge clk);
    chk("rst_over_seed_state", state_out, 7'h7F);
    chk("rst_over_seed_lockup", lockup, 0);
    rst = 1'b0; seed_load = 1'b0;

`ifdef MSEQ_CHECKER_EN
    // Loopback: lock after 7 bits, clean for 1000 bits, one flipped bit gives 3 errors.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    loop_mode = 1'b1;
    push_ref(1020);
    ena = 1'b1;
    nv = 0; errp = 0; sync_low = 0;
    for (int c = 0; c < 1200 && nv < 1020; c++) begin
      @(negedge clk);
      if (data_valid) begin
        nv++;
        if (nv == 7) chk("sync_before_7_bits", chk_sync, 0);
        if (nv == 8) chk("sync_after_7_bits", chk_sync, 1);
        if (nv == 1000) begin
          chk("err_cnt_clean_1000", err_cnt, 0);
          chk("no_err_pulses_1000", errp, 0);
          flip = 1'b1;
        end
        if (nv == 1001) flip = 1'b0;
        if (nv == 1020) ena = 1'b0;
      end
      if (chk_err) errp++;
      if (nv > 8 && !chk_sync) sync_low++;
    end
    ena = 1'b0;
    @(negedge clk);
    if (chk_err) errp++;
    chk("loop_bit_count", nv, 1020);
    chk("flip_err_pulses", errp, 3);
    chk("flip_err_cnt", err_cnt, 3);
    chk("flip_sync_held", sync_low, 0);
    chk("loop_queue_drained", expq.size(), 0);
    loop_mode = 1'b0;

    // Random input: lock is acquired on fill, then lost on mismatches.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ext_valid = 1'b1;
    got = 0;
    for (int c = 0; c < 40 && got == 0; c++) begin
      ext_in = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (chk_sync) got = 1;
    end
    chk("rand_sync_acquired", got, 1);
    dropped = 0;
    for (int c = 0; c < 48 && dropped == 0; c++) begin
      ext_in = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (!chk_sync) dropped = 1;
    end
    chk("rand_sync_dropped", dropped, 1);
    chk("rand_err_cnt_ge_thr", (err_cnt >= 16'd4), 1);
`else
    ext_valid = 1'b1;
    nz = 0;
    for (int c = 0; c < 30; c++) begin
      ext_in = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (chk_sync || chk_err || err_cnt != 16'd0) nz++;
    end
    chk("checker_tied_off", nz, 0);
`endif

    // Reset mid-run with generator enabled and checker still strobed.
    seed_load = 1'b1; seed_in = 7'h01;
    @(negedge clk);
    seed_load = 1'b0; ena = 1'b1;
    @(negedge clk);
    chk("pre_rst_load", load, 1);
    chk("pre_rst_state", state_out, 7'h02);
    rst = 1'b1;
    ext_in = 1'($urandom_range(0, 1));
    @(negedge clk);
    check_reset("rst_mid_run");
    rst = 1'b0; ena = 1'b0; ext_valid = 1'b0;
    @(negedge clk);
    chk("final_queue_empty", expq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
